// File: rtl/memory_data_buffer.sv
// Formatting FIFO for memory read data: each load is reshaped by MODE on entry,
// stored, and presented in order on D_OUT with a ready/valid handshake on both sides.
module memory_data_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           D_IN,
    input  logic [1:0]                 MODE,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           D_OUT,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             drop_q, drop_d;
    logic             push, pop;
    logic [WIDTH-1:0] fmt_data;

    assign in_ready  = (count_q < FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Byte loads only ever look at the low 16 bits of the read word.
    always_comb begin
        fmt_data = D_IN;
        unique case (MODE)
            2'b00: fmt_data = D_IN;
            2'b01: fmt_data = {{(WIDTH-8){1'b0}}, D_IN[7:0]};
            2'b10: fmt_data = {{(WIDTH-8){D_IN[7]}}, D_IN[7:0]};
            2'b11: fmt_data = {{(WIDTH-8){1'b0}}, D_IN[15:8]};
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            drop_d   = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (in_valid && !in_ready) drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= fmt_data;
    end

    assign D_OUT = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;
    assign drop  = drop_q;

endmodule
